mem_arbiter: RTL and testbench

//  Memory controller downstream of the icache/dcache pair. Arbitrates their miss/writeback

---
 rtl/mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates icache/dcache miss and writeback traffic onto one single-ported RAM.
// Build macro MEM_ARB_PERF_EN adds per-client completion counters on ports icount/dcount.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ramready
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       icount,
  output logic [31:0]       dcount
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DACC = 2'd1;
  localparam logic [1:0] IACC = 2'd2;

  localparam int              CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [CNT_W-1:0]  r_starve;
  logic [CNT_W-1:0]  w_starve_nxt;
  logic              r_ren;
  logic              r_wen;
  logic              w_ren_nxt;
  logic              w_wen_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] r_store;
  logic [DATA_W-1:0] w_store_nxt;

  logic w_d_req;
  logic w_d_grant;
  logic w_i_grant;
  logic w_d_done;
  logic w_i_done;

  // dcache wins unless it has already starved a waiting icache STARVE_MAX times
  assign w_d_req   = dREN | dWEN;
  assign w_d_grant = (r_state == IDLE) && w_d_req && ((r_starve < STARVE_LIM) || !iREN);
  assign w_i_grant = (r_state == IDLE) && !w_d_grant && iREN;
  assign w_d_done  = (r_state == DACC) && ramready;
  assign w_i_done  = (r_state == IACC) && ramready;

  always_comb begin
    w_state_nxt = r_state;
    w_ren_nxt   = r_ren;
    w_wen_nxt   = r_wen;
    w_addr_nxt  = r_addr;
    w_store_nxt = r_store;
    case (r_state)
      IDLE: begin
        if (w_d_grant) begin
          w_state_nxt = DACC;
          w_wen_nxt   = dWEN;
          w_ren_nxt   = !dWEN;
          w_addr_nxt  = daddr;
          w_store_nxt = dstore;
        end else if (w_i_grant) begin
          w_state_nxt = IACC;
          w_wen_nxt   = 1'b0;
          w_ren_nxt   = 1'b1;
          w_addr_nxt  = iaddr;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      DACC, IACC: begin
        if (ramready) begin
          w_state_nxt = IDLE;
          w_ren_nxt   = 1'b0;
          w_wen_nxt   = 1'b0;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_ren_nxt   = 1'b0;
        w_wen_nxt   = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_starve_nxt = r_starve;
    if (w_d_grant && iREN) begin
      if (r_starve < STARVE_LIM) begin
        w_starve_nxt = r_starve + CNT_W'(1);
      end else begin
        w_starve_nxt = r_starve;
      end
    end else if (w_i_grant) begin
      w_starve_nxt = '0;
    end else if ((r_state == IDLE) && !iREN) begin
      w_starve_nxt = '0;
    end else begin
      w_starve_nxt = r_starve;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= IDLE;
      r_starve <= '0;
      r_ren    <= 1'b0;
      r_wen    <= 1'b0;
      r_addr   <= '0;
      r_store  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
      r_ren    <= w_ren_nxt;
      r_wen    <= w_wen_nxt;
      r_addr   <= w_addr_nxt;
      r_store  <= w_store_nxt;
    end
  end

  // Response is a same-cycle pass-through of ramload; a dcache write returns zero
  assign iwait    = !w_i_done;
  assign dwait    = !w_d_done;
  assign iload    = w_i_done ? ramload : '0;
  assign dload    = (w_d_done && !r_wen) ? ramload : '0;
  assign ramREN   = r_ren;
  assign ramWEN   = r_wen;
  assign ramaddr  = r_addr;
  assign ramstore = r_store;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] r_icount;
  logic [31:0] r_dcount;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_icount <= 32'd0;
      r_dcount <= 32'd0;
    end else begin
      if (w_i_done) begin
        r_icount <= r_icount + 32'd1;
      end
      if (w_d_done) begin
        r_dcount <= r_dcount + 32'd1;
      end
    end
  end

  assign icount = r_icount;
  assign dcount = r_dcount;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed stimulus for mem_arbiter against a transaction-level
// reference (owner / starve count / word memory) plus a behavioural RAM with variable latency.
module tb_mem_arbiter;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;

  logic              CLK = 1'b0;
  logic              RST;
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  logic [DATA_W-1:0] iload;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dwait;
  logic [DATA_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic              ramready;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]       icount;
  logic [31:0]       dcount;
`endif

  always #5 CLK = ~CLK;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready)
`ifdef MEM_ARB_PERF_EN
    , .icount(icount), .dcount(dcount)
`endif
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] ram_mem [256];
  logic [31:0] ref_mem [256];

  // behavioural RAM
  bit ram_busy;
  int ram_cnt, ram_lat, fixed_lat;
  bit stray_en;

  // reference model: 0 = idle, 1 = dcache owns RAM, 2 = icache owns RAM
  int          m_owner, m_starve, m_icnt, m_dcnt;
  bit          m_write;
  logic [31:0] m_addr, m_data;

  // client stimulus state
  bit          i_pend, d_pend, d_w, d_both, d_hold, rnd_mode;
  logic [31:0] i_a, d_a, d_s;
  bit          i_done_obs, d_done_obs;
  int          i_obs_cnt, d_obs_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic client_drive();
    if (i_done_obs) i_pend = 1'b0;
    if (d_done_obs && !d_hold) d_pend = 1'b0;
    if (rnd_mode) begin
      if (!i_pend && m_owner != 2 && $urandom_range(0, 2) == 0) begin
        i_pend = 1'b1;
        i_a    = $urandom & 32'hFFFF_FFFC;
      end else if (i_pend && $urandom_range(0, 15) == 0) begin
        i_pend = 1'b0;
      end
      if (!d_pend && m_owner != 1 && $urandom_range(0, 1) == 0) begin
        d_pend = 1'b1;
        d_w    = 1'($urandom_range(0, 1));
        d_both = 1'($urandom_range(0, 1));
        d_a    = $urandom & 32'hFFFF_FFFC;
        d_s    = $urandom;
      end else if (d_pend && $urandom_range(0, 15) == 0) begin
        d_pend = 1'b0;
      end
    end
    iREN   = i_pend;
    iaddr  = i_a;
    dWEN   = d_pend && d_w;
    dREN   = d_pend && (!d_w || d_both);
    daddr  = d_a;
    dstore = d_s;
  endtask

  task automatic drive_ram();
    ramready = 1'b0;
    ramload  = $urandom;
    if (ramREN || ramWEN) begin
      if (!ram_busy) begin
        ram_busy = 1'b1;
        ram_cnt  = 0;
        ram_lat  = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
      end else begin
        ram_cnt++;
      end
      if (ram_cnt == ram_lat) begin
        ramready = 1'b1;
        ram_busy = 1'b0;
        if (ramWEN) ram_mem[ramaddr[9:2]] = ramstore;
        else        ramload = ram_mem[ramaddr[9:2]];
      end
    end else begin
      ram_busy = 1'b0;
      if (stray_en && $urandom_range(0, 7) == 0) ramready = 1'b1;
    end
  endtask

  task automatic check_and_model();
    bit          exp_ren, exp_wen, exp_id, exp_dd;
    logic [31:0] exp_rd;
    exp_ren = (m_owner == 2) || (m_owner == 1 && !m_write);
    exp_wen = (m_owner == 1) && m_write;
    exp_id  = (m_owner == 2) && ramready;
    exp_dd  = (m_owner == 1) && ramready;
    exp_rd  = ref_mem[m_addr[9:2]];
    chk("ramREN", ramREN, exp_ren);
    chk("ramWEN", ramWEN, exp_wen);
    if (m_owner != 0) chk("ramaddr", ramaddr, m_addr);
    if (exp_wen) chk("ramstore", ramstore, m_data);
    chk("iwait", iwait, !exp_id);
    chk("dwait", dwait, !exp_dd);
    if (exp_id) chk("iload", iload, exp_rd);
    if (exp_dd) chk("dload", dload, m_write ? 32'd0 : exp_rd);
`ifdef MEM_ARB_PERF_EN
    chk("icount", icount, m_icnt);
    chk("dcount", dcount, m_dcnt);
`endif
    i_done_obs = (iwait === 1'b0);
    d_done_obs = (dwait === 1'b0);
    if (i_done_obs) i_obs_cnt++;
    if (d_done_obs) d_obs_cnt++;
    // advance the reference to the state the next edge should produce
    if (m_owner != 0) begin
      if (ramready) begin
        if (m_owner == 1) begin
          if (m_write) ref_mem[m_addr[9:2]] = m_data;
          m_dcnt++;
        end else begin
          m_icnt++;
        end
        m_owner = 0;
      end
    end else if ((dREN || dWEN) && (m_starve < STARVE_MAX || !iREN)) begin
      m_owner  = 1;
      m_write  = dWEN;
      m_addr   = daddr;
      m_data   = dstore;
      m_starve = iREN ? ((m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX) : 0;
    end else if (iREN) begin
      m_owner  = 2;
      m_addr   = iaddr;
      m_starve = 0;
    end else begin
      m_starve = 0;
    end
  endtask

  task automatic run_cycle();
    @(posedge CLK);
    #1;
    client_drive();
    drive_ram();
    @(negedge CLK);
    check_and_model();
  endtask

  task automatic run_until(input bit want_i, input int max, output int n);
    n = -1;
    for (int k = 1; k <= max; k++) begin
      run_cycle();
      if (want_i ? i_done_obs : d_done_obs) begin
        n = k;
        break;
      end
    end
  endtask

  // hold reset with both clients requesting and ramready high
  task automatic do_reset(input int ncyc);
    @(posedge CLK);
    #1;
    RST = 1'b1; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0; ramready = 1'b1; ramload = $urandom;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      chk("rst_ramREN", ramREN, 1'b0);
      chk("rst_ramWEN", ramWEN, 1'b0);
      chk("rst_iwait", iwait, 1'b1);
      chk("rst_dwait", dwait, 1'b1);
      chk("rst_iload", iload, 32'd0);
      chk("rst_dload", dload, 32'd0);
      chk("rst_ramaddr", ramaddr, 32'd0);
      chk("rst_ramstore", ramstore, 32'd0);
`ifdef MEM_ARB_PERF_EN
      chk("rst_icount", icount, 32'd0);
      chk("rst_dcount", dcount, 32'd0);
`endif
    end
    RST = 1'b0; iREN = 1'b0; dREN = 1'b0; ramready = 1'b0;
    i_pend = 1'b0; d_pend = 1'b0; d_hold = 1'b0;
    i_done_obs = 1'b0; d_done_obs = 1'b0; ram_busy = 1'b0;
    m_owner = 0; m_starve = 0; m_addr = 32'd0; m_data = 32'd0; m_icnt = 0; m_dcnt = 0;
  endtask

  initial begin
    int n, d0;
    RST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramready = 1'b0;
    i_pend = 1'b0; d_pend = 1'b0; d_w = 1'b0; d_both = 1'b0; d_hold = 1'b0; rnd_mode = 1'b0;
    i_a = '0; d_a = '0; d_s = '0; i_obs_cnt = 0; d_obs_cnt = 0;
    fixed_lat = 0; stray_en = 1'b0;
    for (int k = 0; k < 256; k++) begin
      ram_mem[k] = $urandom;
      ref_mem[k] = ram_mem[k];
    end
    ram_mem[16] = 32'hDEADBEEF;
    ref_mem[16] = 32'hDEADBEEF;

    do_reset(3);

    // icache read, RAM answers 3 cycles after the strobe
    fixed_lat = 3; i_pend = 1'b1; i_a = 32'h40;
    run_until(1'b1, 20, n);
    chk("t2_latency", n, 5);
    run_cycle();

    // minimum latency: request-to-done of 2 cycles
    fixed_lat = 1; i_pend = 1'b1; i_a = 32'h48;
    run_until(1'b1, 20, n);
    chk("min_latency", n, 3);
    run_cycle();

    // simultaneous icache read and dcache write: dcache first, one IDLE gap
    fixed_lat = 2;
    i_pend = 1'b1; i_a = 32'h44;
    d_pend = 1'b1; d_w = 1'b1; d_both = 1'b0; d_a = 32'h100; d_s = 32'h12345678;
    run_until(1'b0, 20, n);
    chk("t3_d_first", n, 4);
    run_until(1'b1, 20, n);
    chk("t3_i_after_gap", n, 4);
    d_pend = 1'b1; d_w = 1'b0; d_a = 32'h100;
    run_until(1'b0, 20, n);
    chk("t3_readback_done", n, 4);
    run_cycle();

    // dREN held with iREN: STARVE_MAX dcache grants, then the icache
    fixed_lat = 1;
    d_hold = 1'b1; d_pend = 1'b1; d_w = 1'b0; d_a = 32'h200;
    i_pend = 1'b1; i_a = 32'h204;
    d0 = d_obs_cnt;
    run_until(1'b1, 100, n);
    chk("t4_dgrants", d_obs_cnt - d0, STARVE_MAX);
    d_hold = 1'b0; d_pend = 1'b0;
    run_cycle();
    run_cycle();

    // dcache drops its request mid-access; access completes, icache granted next
    fixed_lat = 4;
    d_pend = 1'b1; d_w = 1'b0; d_a = 32'h80;
    i_pend = 1'b1; i_a = 32'h84;
    run_cycle();
    run_cycle();
    d_pend = 1'b0;
    d0 = d_obs_cnt;
    run_until(1'b1, 40, n);
    chk("t5_d_pulse", d_obs_cnt - d0, 1);
    chk("t5_i_done", n, 10);
    run_cycle();
    chk("t5_no_stuck_ren", ramREN, 1'b0);

    // randomized traffic with stray ramready pulses and a reset mid-run
    fixed_lat = 0; stray_en = 1'b1; rnd_mode = 1'b1;
    for (int k = 0; k < 1200; k++) run_cycle();
    rnd_mode = 1'b0;
    do_reset(2);
    rnd_mode = 1'b1;
    for (int k = 0; k < 1200; k++) run_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
